// File: rtl/avalon_st_pkt_enforcer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | avalon_st_pkt_enforcer                                                     |
// | Zero-latency Avalon-ST framing enforcer with saturating error counters.    |
// | Length limit built only when AVALON_ST_PKT_ENFORCER_LEN_CHECK_EN defined.  |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module avalon_st_pkt_enforcer #(
  parameter int DATA_W        = 32,
  parameter int EMPTY_W       = (DATA_W / 8 > 1) ? $clog2(DATA_W / 8) : 1,
  parameter int MAX_PKT_BEATS = 256,
  parameter int CNT_W         = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [DATA_W-1:0]  in_data,
  input  logic               in_valid,
  input  logic               in_sop,
  input  logic               in_eop,
  input  logic [EMPTY_W-1:0] in_empty,
  output logic               in_rdy,
  output logic [DATA_W-1:0]  out_data,
  output logic               out_valid,
  output logic               out_sop,
  output logic               out_eop,
  output logic [EMPTY_W-1:0] out_empty,
  output logic               out_err,
  input  logic               out_rdy,
  output logic               err_no_sop,
  output logic               err_second_sop,
  output logic               err_oversize,
  input  logic               cnt_clr,
  output logic [CNT_W-1:0]   cnt_no_sop,
  output logic [CNT_W-1:0]   cnt_second_sop,
  output logic [CNT_W-1:0]   cnt_oversize
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_IN_PKT  = 2'd1,
    S_DISCARD = 2'd2
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic               w_in_rdy;
  logic               w_acc;
  logic               w_at_max;
  logic               w_out_valid;
  logic               w_out_sop;
  logic               w_out_eop;
  logic [EMPTY_W-1:0] w_out_empty;
  logic               w_out_err;
  logic               w_err_no_sop;
  logic               w_err_second_sop;
  logic               w_err_oversize;

  // DISCARD swallows the tail regardless of downstream; reset holds the source off.
  assign w_in_rdy = rst & ((r_state == S_DISCARD) | out_rdy);
  assign w_acc    = in_valid & w_in_rdy;

`ifdef AVALON_ST_PKT_ENFORCER_LEN_CHECK_EN
  localparam int BCW = $clog2(MAX_PKT_BEATS + 1);

  logic [BCW-1:0] r_beat_cnt;

  assign w_at_max = (r_beat_cnt == BCW'(MAX_PKT_BEATS - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_beat_cnt <= '0;
    end else if (w_acc) begin
      if (r_state == S_IDLE && in_sop && !in_eop) begin
        r_beat_cnt <= BCW'(1);
      end else if (r_state == S_IN_PKT && !in_sop && !in_eop && !w_at_max) begin
        r_beat_cnt <= r_beat_cnt + BCW'(1);
      end
    end
  end
`else
  assign w_at_max = 1'b0;

  // Length limit not built; the parameter only documents the interface.
  if (MAX_PKT_BEATS < 2) begin : g_max_len_unused
  end
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt      = r_state;
    w_out_valid      = 1'b0;
    w_out_sop        = 1'b0;
    w_out_eop        = 1'b0;
    w_out_empty      = '0;
    w_out_err        = 1'b0;
    w_err_no_sop     = 1'b0;
    w_err_second_sop = 1'b0;
    w_err_oversize   = 1'b0;
    if (rst && in_valid) begin
      case (r_state)
        S_IDLE: begin
          if (!in_sop) begin
            w_err_no_sop = w_acc;
          end else begin
            w_out_valid = 1'b1;
            w_out_sop   = 1'b1;
            w_out_eop   = in_eop;
            if (in_eop) begin
              w_out_empty = in_empty;
            end else if (w_acc) begin
              w_state_nxt = S_IN_PKT;
            end
          end
        end
        S_IN_PKT: begin
          w_out_valid = 1'b1;
          // A repeated SOP outranks the length limit on the same beat.
          if (in_sop) begin
            w_out_eop        = 1'b1;
            w_out_err        = 1'b1;
            w_err_second_sop = w_acc;
            if (w_acc) begin
              w_state_nxt = in_eop ? S_IDLE : S_DISCARD;
            end
          end else if (in_eop) begin
            w_out_eop   = 1'b1;
            w_out_empty = in_empty;
            if (w_acc) begin
              w_state_nxt = S_IDLE;
            end
          end else if (w_at_max) begin
            w_out_eop      = 1'b1;
            w_out_err      = 1'b1;
            w_err_oversize = w_acc;
            if (w_acc) begin
              w_state_nxt = S_DISCARD;
            end
          end
        end
        S_DISCARD: begin
          if (w_acc && in_eop) begin
            w_state_nxt = S_IDLE;
          end
        end
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  assign in_rdy         = w_in_rdy;
  assign out_valid      = w_out_valid;
  assign out_data       = w_out_valid ? in_data : '0;
  assign out_sop        = w_out_sop;
  assign out_eop        = w_out_eop;
  assign out_empty      = w_out_empty;
  assign out_err        = w_out_err;
  assign err_no_sop     = w_err_no_sop;
  assign err_second_sop = w_err_second_sop;
  assign err_oversize   = w_err_oversize;

`ifdef AVALON_ST_PKT_ENFORCER_LEN_CHECK_EN
  localparam int N_CNT = 3;
`else
  localparam int N_CNT = 2;
`endif

  logic [2:0] w_pulse;
  assign w_pulse = {w_err_oversize, w_err_second_sop, w_err_no_sop};

  for (genvar i = 0; i < N_CNT; i++) begin : g_cnt
    logic [CNT_W-1:0] r_cnt;
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        r_cnt <= '0;
      end else if (cnt_clr) begin
        r_cnt <= '0;
      end else if (w_pulse[i] && r_cnt != '1) begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end
  end

  assign cnt_no_sop     = g_cnt[0].r_cnt;
  assign cnt_second_sop = g_cnt[1].r_cnt;
`ifdef AVALON_ST_PKT_ENFORCER_LEN_CHECK_EN
  assign cnt_oversize   = g_cnt[2].r_cnt;
`else
  assign cnt_oversize   = '0;
`endif

endmodule
`default_nettype wire

// File: doc/avalon_st_pkt_enforcer.md
# avalon_st_pkt_enforcer

Parametrised Avalon-ST protocol enforcer placed between an untrusted streaming source and trusted downstream logic. Passes well-formed packets unchanged with zero latency, drops beats outside packets, closes packets broken by a repeated SOP or by exceeding a maximum length, and discards the remainder of the broken packet. It keeps saturating per-error statistics counters for software.

## Interface
- DATA_W, 32, data bus width in bits; multiple of 8, at least 8.
- EMPTY_W, $clog2(DATA_W/8) (min 1), empty field width.
- MAX_PKT_BEATS, 256, maximum legal packet length in beats; at least 2.
- CNT_W, 16, error counter width.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-low.
- in_data  in  DATA_W  untrusted data.
- in_valid / in_sop / in_eop  in  1 each  untrusted qualifiers.
- in_empty  in  EMPTY_W  untrusted empty.
- in_rdy  out  1  backpressure to the source.
- out_data  out  DATA_W  enforced data.
- out_valid / out_sop / out_eop  out  1 each  enforced qualifiers.
- out_empty  out  EMPTY_W  enforced empty.
- out_err  out  1  high on a forced-EOP beat; marks the packet as truncated.
- out_rdy  in  1  downstream ready.
- err_no_sop / err_second_sop / err_oversize  out  1 each  single-cycle error pulses.
- cnt_clr  in  1  synchronous clear of all counters.
- cnt_no_sop / cnt_second_sop / cnt_oversize  out  CNT_W each  saturating error counts.

## Operation
- A beat is accepted when in_valid & in_rdy.
- IDLE:
  - in_rdy = out_rdy.
  - Valid beat with sop=0: dropped (out_valid=0) and err_no_sop is pulsed.
  - sop & eop: passed as a single-beat packet; state stays IDLE.
  - sop & ~eop: passed; on acceptance, go to IN_PKT with beat_cnt=1.
- IN_PKT:
  - in_rdy = out_rdy.
  - Beats pass with out_sop=0.
  - Valid & eop: passed; on acceptance, go to IDLE.
  - Valid & sop (with or without eop): passed with out_eop=1, out_err=1, out_empty=0. Pulse err_second_sop and go to DISCARD. If eop was also set, go to IDLE instead.
  - Accepted beat with no eop or sop while beat_cnt == MAX_PKT_BEATS-1: output with out_eop=1, out_err=1, out_empty=0. Pulse err_oversize and go to DISCARD.
  - Second-SOP takes priority over oversize on the same beat; only one pulse is raised.
  - Otherwise, beat_cnt increments on each accepted beat.
- DISCARD:
  - in_rdy=1 and out_valid=0.
  - Any valid beat is consumed silently. A valid beat with eop returns the block to IDLE.
  - No error pulses are raised in DISCARD.
- Output data: out_data = in_data when out_valid, else 0.
- Output empty: out_empty = in_empty only on a passed beat whose input eop=1, else 0.
- out_err is 0 except on forced-EOP beats.
- Error pulses fire only on accepted beats (err_no_sop, err_second_sop, err_oversize).
- Counters:
  - Each counter increments on its pulse and saturates at 2^CNT_W-1.
  - cnt_clr takes precedence over a same-cycle increment; the counter reads 0 next cycle.

## Timing
- Datapath is combinational: in → out and out_rdy → in_rdy, zero latency.
- State, beat_cnt and counters update on posedge clk, on accepted beats only.
- Reset (rst=0, asynchronous): state=IDLE, beat_cnt=0, counters=0.
- While rst is low: in_rdy=0, out_valid=0, and all pulses are 0.
- Reset mid-packet: the partial packet is abandoned without a forced EOP. The next beat must carry sop, otherwise the err_no_sop rule applies.
- Stalled beats (valid & ~rdy) change no state and raise no pulse. The beat is re-evaluated every cycle until accepted.
- beat_cnt width is $clog2(MAX_PKT_BEATS+1) and it never wraps.

## Configuration
- AVALON_ST_PKT_ENFORCER_LEN_CHECK_EN defined:
  - Length enforcement is active as described above.
- Undefined:
  - beat_cnt and the oversize logic are not built; MAX_PKT_BEATS is ignored.
  - err_oversize is tied to 0 and cnt_oversize is tied to 0.
  - Packets of any length pass.

## Test plan
- 4-beat packet (sop on beat 0, eop on beat 3, empty=2), out_rdy=1 → identical 4 output beats, out_empty=2 on the last beat only, no pulses, all counters 0.
- Two valid beats with sop=0 in IDLE → out_valid stays 0, err_no_sop pulses twice, cnt_no_sop=2.
- Packet whose beat 2 has sop=1, followed by beats 3–5 with eop on beat 5 → beat 2 output with out_eop=1 and out_err=1; beats 3–5 consumed with out_valid=0; cnt_second_sop=1; state returns to IDLE.
- MAX_PKT_BEATS=4, 6-beat packet, macro defined → beat 3 output with out_eop=1 and out_err=1; beats 4–5 discarded; cnt_oversize=1. Same stimulus with the macro undefined → all 6 beats pass unchanged.
- out_rdy toggled 0/1 every cycle during a 3-beat packet → in_rdy mirrors out_rdy; each beat output exactly once; beat_cnt advances only on acceptance.
- CNT_W=2 with 5 no-SOP beats → counter saturates at 3; cnt_clr pulsed on the same cycle as a 6th error → counter reads 0.
